gpio_bank: RTL and testbench
============================

GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter CHANNELS, default 8, number of tristate pins in the bank, legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2, input synchroniser depth, legal range 2..3.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, stable cycles required before a filtered input changes; 0 = bypass.
REQ-004 cpu_clock  input  1  sole clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 addr  input  3  register select.
REQ-007 write_en  input  1  write strobe, one cycle per write.
REQ-008 data_in  input  16  write data.
REQ-009 data_out  output  16  read data, registered.
REQ-010 irq  output  1  level interrupt, high while any event bit is set.
REQ-011 pin_out  output  CHANNELS  per-pin drive value, to SB_IO D_OUT_0.
REQ-012 pin_config  output  CHANNELS  per-pin output enable, 1 = drive, to SB_IO OUTPUT_ENABLE.
REQ-013 pin_in  input  CHANNELS  raw asynchronous pin level, from SB_IO D_IN_0.

Function
REQ-014 Register map SHALL be: 0 OUT (rw), 1 CONFIG (rw), 2 IN (ro, filtered), 3 RISE_EN (rw), 4 FALL_EN (rw), 5 EVENT (read; write-1-to-clear), 6 OUT_SET (wo, OR into OUT), 7 OUT_CLR (wo, AND-NOT into OUT).
REQ-015 A write SHALL take effect at the cpu_clock edge where write_en=1; pin_out/pin_config reflect it on the following cycle.
REQ-016 data_out SHALL present the register selected by addr one cycle after addr is applied, regardless of write_en; reads of 6 and 7 SHALL return OUT.
REQ-017 Bits at or above CHANNELS SHALL be ignored on write and read as 0.
REQ-018 Each pin_in bit SHALL pass through SYNC_STAGES flops before any other use.
REQ-019 Debounce: per channel, a counter SHALL increment while the synchronised value differs from the filtered value and SHALL reset to 0 when they match; when it reaches DEBOUNCE_CYCLES the filtered value SHALL flip and the counter clear.
REQ-020 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); it SHALL never wrap.
REQ-021 With DEBOUNCE_CYCLES=0 the filtered value SHALL equal the last synchroniser stage.
REQ-022 A filtered 0->1 transition with RISE_EN bit set, or 1->0 with FALL_EN bit set, SHALL set the EVENT bit in the same cycle the filtered value changes.
REQ-023 If an event set and a write-1-to-clear of the same EVENT bit coincide, set SHALL win.
REQ-024 Clearing an enable bit SHALL NOT clear an already-latched EVENT bit.
REQ-025 irq SHALL be registered OR of EVENT bits, one cycle after EVENT changes.
REQ-026 Input sampling, debounce and edge detection SHALL run on every pin regardless of CONFIG (output pins read back their driven level).

Reset
REQ-027 On reset_n low all state SHALL clear asynchronously: OUT=0, CONFIG=0 (all pins input), RISE_EN=FALL_EN=0, EVENT=0, synchronisers, filtered values and counters 0, data_out=0, irq=0.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; no event SHALL result from reset release alone while enables are 0.
REQ-029 Release of reset_n SHALL be synchronous to cpu_clock externally; the block adds no release synchroniser.

Structure
REQ-030 Register address constants (GPIO_OUT..GPIO_OUT_CLR) SHALL live in the shared peripheral constants include.
REQ-031 Per-channel synchroniser, debounce counter and filtered flop SHALL be one sub-module, gpio_debounce, instantiated CHANNELS times via generate.
REQ-032 SB_IO primitives SHALL remain in the board top level; gpio_bank SHALL contain no vendor cells.

Verification
REQ-033 CHANNELS=8: write OUT=0x00A5, CONFIG=0x00FF -> pin_out=0xA5, pin_config=0xFF next cycle; read addr 0 -> 0x00A5.
REQ-034 OUT=0x00F0, write OUT_SET=0x0003 then OUT_CLR=0x0030 -> OUT=0x00C3; write OUT=0xFFFF -> reads 0x00FF.
REQ-035 DEBOUNCE_CYCLES=16, pin_in[2] high 10 cycles then low, then high 20 cycles -> IN[2] stays 0 for the glitch, becomes 1 exactly SYNC_STAGES+16 cycles after the stable rise.
REQ-036 RISE_EN=0x0004, pin 2 debounced rise -> EVENT=0x0004, irq=1 one cycle later; write EVENT=0x0004 -> EVENT=0, irq=0.
REQ-037 Write-1-to-clear EVENT[2] on the same edge a new rise on pin 2 is filtered -> EVENT[2] remains 1, irq stays 1.
REQ-038 reset_n pulsed low mid-debounce with pins driven -> all outputs 0 immediately (asynchronously), EVENT=0, no irq after release.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// ============================================================================
//  gpio_bank_pkg
//  Register map and bus-width constants shared by GPIO bank peripherals.
//  Rev 1.0
// ============================================================================
`default_nettype none

package gpio_bank_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      GPIO_OUT     = 3'd0,
      GPIO_CONFIG  = 3'd1,
      GPIO_IN      = 3'd2,
      GPIO_RISE_EN = 3'd3,
      GPIO_FALL_EN = 3'd4,
      GPIO_EVENT   = 3'd5,
      GPIO_OUT_SET = 3'd6,
      GPIO_OUT_CLR = 3'd7
   } gpio_reg_e;

endpackage

`default_nettype wire

// File: rtl/gpio_debounce.sv
// ============================================================================
//  gpio_debounce
//  One pin: input synchroniser, stability counter and filtered level flop.
//  Rev 1.0
// ============================================================================
`default_nettype none

module gpio_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic cpu_clock,
   input  logic reset_n,
   input  logic pin_in,
   output logic filtered,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   synced;
   logic                   flip;

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pin_in};
      end
   end

   assign synced = sync[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         // Filtered level is the last stage, so it changes when the stage before it differs.
         assign filtered = synced;
         assign flip     = sync[SYNC_STAGES-2] ^ synced;
      end else begin : g_filter
         localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] count;
         logic          held;

         assign flip = (synced != held) && (count == LAST);

         always_ff @(posedge cpu_clock or negedge reset_n) begin
            if (!reset_n) begin
               count <= '0;
               held  <= 1'b0;
            end else if (synced == held) begin
               count <= '0;
            end else if (flip) begin
               count <= '0;
               held  <= synced;
            end else begin
               count <= count + 1'b1;
            end
         end

         assign filtered = held;
      end
   endgenerate

   // Edge strobes lead the filtered flop so events latch on the same edge.
   assign rise = flip & ~filtered;
   assign fall = flip & filtered;

endmodule

`default_nettype wire

// File: rtl/gpio_bank.sv
// ============================================================================
//  gpio_bank
//  Register-mapped bank of tristate pins with debounced inputs and edge events.
//  Rev 1.0
// ============================================================================
`default_nettype none

module gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int CHANNELS        = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                cpu_clock,
   input  logic                reset_n,
   input  logic [2:0]          addr,
   input  logic                write_en,
   input  logic [DATA_W-1:0]   data_in,
   output logic [DATA_W-1:0]   data_out,
   output logic                irq,
   output logic [CHANNELS-1:0] pin_out,
   output logic [CHANNELS-1:0] pin_config,
   input  logic [CHANNELS-1:0] pin_in
);

   logic [CHANNELS-1:0] out_reg;
   logic [CHANNELS-1:0] config_reg;
   logic [CHANNELS-1:0] rise_en;
   logic [CHANNELS-1:0] fall_en;
   logic [CHANNELS-1:0] event_reg;
   logic [CHANNELS-1:0] filtered;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] wdata;
   logic [CHANNELS-1:0] clear;
   logic [DATA_W-1:0]   rdata;
   gpio_reg_e           sel;
   logic                unused_data;

   assign sel         = gpio_reg_e'(addr);
   assign wdata       = data_in[CHANNELS-1:0];
   assign unused_data = ^data_in;
   assign clear       = (write_en && sel == GPIO_EVENT) ? wdata : '0;
   assign pin_out     = out_reg;
   assign pin_config  = config_reg;

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
         gpio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .cpu_clock (cpu_clock),
            .reset_n   (reset_n),
            .pin_in    (pin_in[i]),
            .filtered  (filtered[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
         );
      end
   endgenerate

   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         out_reg    <= '0;
         config_reg <= '0;
         rise_en    <= '0;
         fall_en    <= '0;
      end else if (write_en) begin
         case (sel)
            GPIO_OUT:     out_reg    <= wdata;
            GPIO_CONFIG:  config_reg <= wdata;
            GPIO_RISE_EN: rise_en    <= wdata;
            GPIO_FALL_EN: fall_en    <= wdata;
            GPIO_OUT_SET: out_reg    <= out_reg | wdata;
            GPIO_OUT_CLR: out_reg    <= out_reg & ~wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (sel)
         GPIO_OUT, GPIO_OUT_SET, GPIO_OUT_CLR: rdata = DATA_W'(out_reg);
         GPIO_CONFIG:  rdata = DATA_W'(config_reg);
         GPIO_IN:      rdata = DATA_W'(filtered);
         GPIO_RISE_EN: rdata = DATA_W'(rise_en);
         GPIO_FALL_EN: rdata = DATA_W'(fall_en);
         GPIO_EVENT:   rdata = DATA_W'(event_reg);
         default:      rdata = '0;
      endcase
   end

   // A new edge overrides a simultaneous write-1-to-clear of the same bit.
   always_ff @(posedge cpu_clock or negedge reset_n) begin
      if (!reset_n) begin
         event_reg <= '0;
         irq       <= 1'b0;
         data_out  <= '0;
      end else begin
         event_reg <= (event_reg & ~clear) | (rise & rise_en) | (fall & fall_en);
         irq       <= |event_reg;
         data_out  <= rdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gpio_bank.sv
// ============================================================================
//  tb_gpio_bank
//  Directed and randomized register/pin traffic compared with a cycle model.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_gpio_bank;

   localparam int CH = 8;
   localparam int SS = 2;
   localparam int DB = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  addr;
   logic        write_en;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        irq;
   logic [7:0]  pin_out;
   logic [7:0]  pin_config;
   logic [7:0]  pin_in;

   int checks = 0;
   int errors = 0;

   // Reference state: the values the DUT registers should hold after each edge.
   logic [7:0]  m_out, m_cfg, m_ren, m_fen, m_evt, m_filt;
   logic        m_irq;
   logic [15:0] m_dout;
   int          run [CH];
   logic [7:0]  hist [$];

   gpio_bank #(
      .CHANNELS        (CH),
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .cpu_clock  (clk),
      .reset_n    (reset_n),
      .addr       (addr),
      .write_en   (write_en),
      .data_in    (data_in),
      .data_out   (data_out),
      .irq        (irq),
      .pin_out    (pin_out),
      .pin_config (pin_config),
      .pin_in     (pin_in)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out = '0; m_cfg = '0; m_ren = '0; m_fen = '0; m_evt = '0; m_filt = '0;
      m_irq = 1'b0; m_dout = '0;
      for (int c = 0; c < CH; c++) run[c] = 0;
      hist.delete();
   endtask

   task automatic model_step(input logic [2:0] a, input logic w, input logic [15:0] d,
                             input logic [7:0] p);
      logic [7:0] synced, rises, falls, clr, wd;
      logic [15:0] rd;
      case (a)
         3'd1:    rd = {8'h00, m_cfg};
         3'd2:    rd = {8'h00, m_filt};
         3'd3:    rd = {8'h00, m_ren};
         3'd4:    rd = {8'h00, m_fen};
         3'd5:    rd = {8'h00, m_evt};
         default: rd = {8'h00, m_out};
      endcase
      synced = (hist.size() >= SS) ? hist[SS-1] : 8'h00;
      rises = '0; falls = '0;
      for (int c = 0; c < CH; c++) begin
         if (synced[c] != m_filt[c]) begin
            run[c]++;
            if (run[c] == DB) begin
               if (synced[c]) rises[c] = 1'b1; else falls[c] = 1'b1;
               m_filt[c] = synced[c];
               run[c] = 0;
            end
         end else begin
            run[c] = 0;
         end
      end
      wd  = d[7:0];
      clr = (w && a == 3'd5) ? wd : 8'h00;
      m_irq  = |m_evt;
      m_evt  = (m_evt & ~clr) | (rises & m_ren) | (falls & m_fen);
      if (w) begin
         case (a)
            3'd0: m_out = wd;
            3'd1: m_cfg = wd;
            3'd3: m_ren = wd;
            3'd4: m_fen = wd;
            3'd6: m_out = m_out | wd;
            3'd7: m_out = m_out & ~wd;
            default: ;
         endcase
      end
      m_dout = rd;
      hist.push_front(p);
      if (hist.size() > 4) void'(hist.pop_back());
   endtask

   // Called at a falling edge; drives one bus cycle, checks after the rising edge.
   task automatic cyc(input logic [2:0] a, input logic w, input logic [15:0] d,
                      input logic [7:0] p);
      addr = a; write_en = w; data_in = d; pin_in = p;
      model_step(a, w, d, p);
      @(posedge clk);
      #1;
      check("data_out", data_out, m_dout);
      check("irq", irq, m_irq);
      check("pin_out", pin_out, m_out);
      check("pin_config", pin_config, m_cfg);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] pins;
      reset_n = 1'b0; addr = '0; write_en = 1'b0; data_in = '0; pin_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_data_out", data_out, 16'h0000);
      check("reset_irq", irq, 1'b0);
      check("reset_pin_out", pin_out, 8'h00);
      check("reset_pin_config", pin_config, 8'h00);
      reset_n = 1'b1;

      pins = 8'h00;
      cyc(3'd0, 1'b1, 16'h00A5, pins);
      cyc(3'd1, 1'b1, 16'h00FF, pins);
      check("out_a5", pin_out, 8'hA5);
      check("cfg_ff", pin_config, 8'hFF);
      cyc(3'd0, 1'b0, 16'h0000, pins);
      check("read_out_a5", data_out, 16'h00A5);

      cyc(3'd0, 1'b1, 16'h00F0, pins);
      cyc(3'd6, 1'b1, 16'h0003, pins);
      cyc(3'd7, 1'b1, 16'h0030, pins);
      cyc(3'd0, 1'b0, 16'h0000, pins);
      check("set_clr_c3", data_out, 16'h00C3);
      cyc(3'd0, 1'b1, 16'hFFFF, pins);
      cyc(3'd6, 1'b0, 16'h0000, pins);
      check("upper_bits_ignored", data_out, 16'h00FF);

      cyc(3'd3, 1'b1, 16'h0004, pins);
      for (int k = 0; k < 10; k++) cyc(3'd2, 1'b0, 16'h0000, 8'h04);
      for (int k = 0; k < 20; k++) cyc(3'd2, 1'b0, 16'h0000, 8'h00);
      check("glitch_filtered", data_out, 16'h0000);
      for (int k = 1; k <= 20; k++) begin
         cyc(3'd2, 1'b0, 16'h0000, 8'h04);
         if (k == SS + DB) check("in2_before_flip", data_out[2], 1'b0);
         if (k == SS + DB + 1) check("in2_after_flip", data_out[2], 1'b1);
      end
      cyc(3'd5, 1'b0, 16'h0000, 8'h04);
      check("event_set", data_out, 16'h0004);
      check("irq_set", irq, 1'b1);
      cyc(3'd5, 1'b1, 16'h0004, 8'h04);
      cyc(3'd5, 1'b0, 16'h0000, 8'h04);
      check("event_cleared", data_out, 16'h0000);
      check("irq_cleared", irq, 1'b0);

      for (int k = 0; k < 22; k++) cyc(3'd2, 1'b0, 16'h0000, 8'h00);
      for (int k = 1; k < SS + DB; k++) cyc(3'd2, 1'b0, 16'h0000, 8'h04);
      cyc(3'd5, 1'b1, 16'h0004, 8'h04);
      cyc(3'd5, 1'b0, 16'h0000, 8'h04);
      check("set_beats_clear", data_out, 16'h0004);
      check("irq_held", irq, 1'b1);

      cyc(3'd4, 1'b1, 16'h00FF, 8'h04);
      for (int k = 0; k < 8; k++) cyc(3'd5, 1'b0, 16'h0000, 8'h0B);
      #3 reset_n = 1'b0;
      #1;
      check("async_pin_out", pin_out, 8'h00);
      check("async_pin_config", pin_config, 8'h00);
      check("async_data_out", data_out, 16'h0000);
      check("async_irq", irq, 1'b0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 40; k++) cyc(3'd5, 1'b0, 16'h0000, 8'h0B);
      check("no_event_after_reset", data_out, 16'h0000);
      check("no_irq_after_reset", irq, 1'b0);

      pins = 8'h0B;
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 29) == 0) pins[c] = ~pins[c];
         cyc(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 16'($urandom), pins);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
